// File: rtl/iterative_div_pkg.sv
// rtl/iterative_div_pkg.sv - shared constants and state encoding for the restoring divider
package iterative_div_pkg;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_bits(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int DIV_CNT_W = cnt_bits(DIV_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/iterative_div_if.sv
// rtl/iterative_div_if.sv - start/operand request and quotient/ready response bundle
interface iterative_div_if
  import iterative_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             ctrl_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_div, operand_a, operand_b,
    input  result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_div, operand_a, operand_b,
    output result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/iterative_div_step.sv
// rtl/iterative_div_step.sv - one combinational restoring step on WIDTH+1-bit unsigned magnitudes
module div_step
  import iterative_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_i,
  input  logic [WIDTH:0] div_i,
  input  logic           bit_i,
  output logic [WIDTH:0] rem_o,
  output logic           q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Remainder stays below the divisor, so the top bit never carries out of the shift.
  assign shifted = (rem_i << 1) | {{WIDTH{1'b0}}, bit_i};
  assign diff    = {1'b0, shifted} - {1'b0, div_i};
  assign q_o     = ~diff[WIDTH+1];
  assign rem_o   = q_o ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/iterative_div.sv
// rtl/iterative_div.sv - signed restoring divider, one quotient bit per clock
module iterative_div
  import iterative_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  iterative_div_if.slave bus
);

  localparam int CW = cnt_bits(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_mag_q, a_mag_d;
  logic [WIDTH:0]   b_mag_q, b_mag_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH:0]   a_ext, b_ext, a_abs, b_abs;
  logic             b_zero;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign a_ext  = {bus.operand_a[WIDTH-1], bus.operand_a};
  assign b_ext  = {bus.operand_b[WIDTH-1], bus.operand_b};
  assign a_abs  = a_ext[WIDTH] ? -a_ext : a_ext;
  assign b_abs  = b_ext[WIDTH] ? -b_ext : b_ext;
  assign b_zero = (bus.operand_b == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .div_i (b_mag_q),
    .bit_i (a_mag_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    zdiv_d   = zdiv_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    // A start in any state discards whatever is in flight.
    if (bus.ctrl_div) begin
      a_mag_d = a_abs;
      b_mag_d = b_abs;
      q_neg_d = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
      rem_d   = '0;
      quo_d   = '0;
      cnt_d   = '0;
      zdiv_d  = b_zero;
      state_d = b_zero ? ST_DONE : ST_CALC;
    end else begin
      case (state_q)
        ST_CALC: begin
          rem_d   = step_rem;
          quo_d   = {quo_q[WIDTH-2:0], step_q};
          a_mag_d = a_mag_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          result_d = q_neg_q ? -quo_q : quo_q;
          exc_d    = zdiv_q;
          rdy_d    = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      zdiv_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      zdiv_q   <= zdiv_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.result         = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_iterative_div.sv
// tb/tb_iterative_div.sv - scoreboard bench for the signed restoring divider
module tb_iterative_div;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           due;
    string        name;
  } exp_t;

  logic clock;
  logic reset_n;
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  iterative_div_if #(.WIDTH(W)) bus ();

  iterative_div #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_, q;
    logic [63:0] qv;
    if (b == '0) return {1'b1, {W{1'b0}}};
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    q = sa / sb_;
    qv = q;
    return {1'b0, qv[W-1:0]};
  endfunction

  // Scoreboard: every RDY pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.data_resultRDY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy edge=%0d got=1 want=0", edge_cnt);
      end else begin
        e = sb.pop_front();
        total++;
        if (bus.result !== e.res) begin
          bad++;
          $display("FAIL %s_result got=%h want=%h", e.name, bus.result, e.res);
        end
        total++;
        if (bus.data_exception !== e.exc) begin
          bad++;
          $display("FAIL %s_exception got=%b want=%b", e.name, bus.data_exception, e.exc);
        end
        total++;
        if (edge_cnt !== e.due) begin
          bad++;
          $display("FAIL %s_latency got_edge=%0d want_edge=%0d", e.name, edge_cnt, e.due);
        end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, input bit push);
    logic [W:0] m;
    int e0;
    bus.ctrl_div  = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    e0 = edge_cnt + 1;
    if (push) begin
      m = model(a, b);
      sb.push_back('{m[W-1:0], m[W], e0 + ((b == '0) ? 1 : W + 1), name});
    end
    @(negedge clock);
    bus.ctrl_div = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic test_reset;
    bit ok;
    reset_n = 1'b0;
    bus.ctrl_div = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clock);
    total++;
    if (bus.result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++;
    if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL reset_exception got=%b want=0", bus.data_exception); end
    total++;
    if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.data_resultRDY); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    drain(ok);
  endtask

  task automatic test_basic;
    bit ok;
    @(negedge clock);
    start_op(32'd7, 32'd2, "pos_pos", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_signs;
    bit ok;
    start_op(32'hFFFF_FFF9, 32'd2, "neg_pos", 1'b1);
    drain(ok);
    start_op(32'd7, 32'hFFFF_FFFE, "pos_neg", 1'b1);
    drain(ok);
    start_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, "neg_neg", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL signs_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_div_zero;
    bit ok;
    start_op(32'd123, 32'd0, "div_zero", 1'b1);
    drain(ok);
    start_op(32'd10, 32'd5, "after_zero", 1'b1);
    drain(ok);
    start_op(32'd0, 32'd9, "zero_dividend", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_overflow;
    bit ok;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, "minneg_by_m1", 1'b1);
    drain(ok);
    start_op(32'h8000_0000, 32'd1, "minneg_by_1", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL overflow_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    start_op(32'd50, 32'd3, "b2b_first", 1'b1);
    drain(ok);
    // We sit in the RDY cycle here, so this start lands on the completion edge.
    start_op(32'd1000, 32'hFFFF_FFF6, "b2b_second", 1'b1);
    drain(ok);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) b = -b;
      start_op(a, b, "random", 1'b1);
      drain(ok);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_abort;
    bit ok;
    start_op(32'd100, 32'd7, "aborted", 1'b0);
    repeat (9) @(negedge clock);
    start_op(32'd9, 32'd3, "restart", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    total++;
    if (bus.result !== 32'd3) begin bad++; $display("FAIL hold_result got=%h want=00000003", bus.result); end
    start_op(32'd100, 32'd7, "killed", 1'b0);
    repeat (14) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.result !== '0) begin bad++; $display("FAIL midreset_result got=%h want=0", bus.result); end
    total++;
    if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL midreset_exception got=%b want=0", bus.data_exception); end
    total++;
    if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL midreset_rdy got=%b want=0", bus.data_resultRDY); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    start_op(32'd100, 32'd7, "post_reset", 1'b1);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_timeout got_pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
